// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator tap frequency meter: selects one of six taps, synchronises it and
// counts its rising edges over a fixed gate window, reporting a saturating count.
module ring_osc_freq_meter #(
    parameter int GATE_CYCLES = 1024,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_tap_in,
    input  logic [2:0]       i_tap_sel,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);
    localparam int TIMER_W = $clog2(GATE_CYCLES);
    localparam int ARM_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
    localparam logic [ARM_W-1:0]   ARM_LAST   = ARM_W'(SYNC_STAGES);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_sel;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [TIMER_W-1:0]     r_timer;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic [CNT_W-1:0]       r_edge_cnt;
    logic                   r_ovf_int;
    logic [CNT_W-1:0]       r_count;
    logic                   r_overflow;

    logic                   w_tap_mux;
    logic                   w_sync_out;
    logic                   w_edge;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_ovf_next;

    // Selections 6 and 7 deliberately measure a constant-zero input.
    assign w_tap_mux  = (r_sel < 3'd6) ? i_tap_in[r_sel] : 1'b0;
    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = w_sync_out & ~r_hist;

    assign o_count    = r_count;
    assign o_overflow = r_overflow;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], w_tap_mux};
            r_hist <= w_sync_out;
        end
    end

    // Saturating edge counter: an edge arriving at all-ones flags overflow instead of wrapping.
    always_comb begin
        w_cnt_next = r_edge_cnt;
        w_ovf_next = r_ovf_int;
        if (w_edge) begin
            if (&r_edge_cnt) begin
                w_ovf_next = 1'b1;
            end else begin
                w_cnt_next = r_edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_ARM;
                end
            end
            S_ARM: begin
                o_busy = 1'b1;
                if (r_arm_cnt == ARM_LAST) begin
                    w_state_next = S_GATE;
                end
            end
            S_GATE: begin
                o_busy = 1'b1;
                if (r_timer == TIMER_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // The result registers load on the final gate edge so they are already valid while done is high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sel      <= 3'd0;
            r_timer    <= '0;
            r_arm_cnt  <= '0;
            r_edge_cnt <= '0;
            r_ovf_int  <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_sel      <= i_tap_sel;
                        r_timer    <= '0;
                        r_arm_cnt  <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_int  <= 1'b0;
                    end
                end
                S_ARM: begin
                    r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                end
                S_GATE: begin
                    r_edge_cnt <= w_cnt_next;
                    r_ovf_int  <= w_ovf_next;
                    r_timer    <= r_timer + TIMER_W'(1);
                    if (r_timer == TIMER_LAST) begin
                        r_count    <= w_cnt_next;
                        r_overflow <= w_ovf_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule
